// File: rtl/dec_pkg.sv
// Shared definitions for the instruction decode stage.
// Holds RISC-V opcode and funct3 constants, the instruction-class encodings
// reported on inst_type, the stage FSM states, the immediate-format selector
// used by dec_imm_gen, and the XLEN-independent slice of the decoded bundle.
package dec_pkg;

    // Major opcodes (inst[6:0]); all end in 2'b11, so a compressed
    // encoding never matches any of them.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3 values with special meaning in the decoder
    localparam logic [2:0] F3_LB    = 3'b000;
    localparam logic [2:0] F3_LH    = 3'b001;
    localparam logic [2:0] F3_LW    = 3'b010;
    localparam logic [2:0] F3_LD    = 3'b011;
    localparam logic [2:0] F3_LBU   = 3'b100;
    localparam logic [2:0] F3_LHU   = 3'b101;
    localparam logic [2:0] F3_LWU   = 3'b110;
    localparam logic [2:0] F3_SRX   = 3'b101;  // SRLI/SRAI share this; inst[30] picks arithmetic
    localparam logic [2:0] F3_PRIV  = 3'b000;  // ECALL/EBREAK
    localparam logic [2:0] F3_JALR  = 3'b000;

    // Instruction classes reported on inst_type
    localparam logic [3:0] INST_ILLEGAL = 4'd0;
    localparam logic [3:0] INST_IMM     = 4'd1;
    localparam logic [3:0] INST_REG     = 4'd2;
    localparam logic [3:0] INST_LUI     = 4'd3;
    localparam logic [3:0] INST_AUIPC   = 4'd4;
    localparam logic [3:0] INST_JAL     = 4'd5;
    localparam logic [3:0] INST_JALR    = 4'd6;
    localparam logic [3:0] INST_BRANCH  = 4'd7;
    localparam logic [3:0] INST_STORE   = 4'd8;
    localparam logic [3:0] INST_ENV     = 4'd9;
    localparam logic [3:0] INST_FENCE   = 4'd10;
    localparam logic [3:0] INST_LOAD    = 4'd12;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    // Decoded control fields whose width does not depend on XLEN
    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] br_cond;
        logic [1:0] mem_size;
        logic       is_mem_sign;
        logic [3:0] inst_type;
        logic       illegal;
    } dec_ctrl_t;

endpackage

// File: rtl/dec_imm_gen.sv
// Combinational immediate extraction for the I/S/B/U/J formats.
// Ports:
//   inst  in  [31:7]  instruction bits above the opcode
//   sel   in  imm_sel_e  which format to extract (IMM_NONE gives zero)
//   imm   out [XLEN-1:0] sign-extended immediate
module dec_imm_gen
    import dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst,
    input  imm_sel_e        sel,
    output logic [XLEN-1:0] imm
);

    // Build every format at 64 bits and truncate, so the same code serves
    // both XLEN settings without zero-width replications.
    logic [63:0] imm_full;

    always_comb begin
        imm_full = '0;
        case (sel)
            IMM_I: imm_full = {{52{inst[31]}}, inst[31:20]};
            IMM_S: imm_full = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm_full = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm_full = {{32{inst[31]}}, inst[31:12], 12'b0};
            IMM_J: imm_full = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm_full = '0;
        endcase
    end

    assign imm = imm_full[XLEN-1:0];

endmodule

// File: rtl/dec_stage.sv
// Registered RV32I/RV64I decode stage between fetch and execute.
// One instruction per cycle is accepted on a valid/ready handshake and the
// decoded bundle appears on the outputs the following cycle. An ECALL/EBREAK
// leaving the stage parks it in HALT until reset.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   in_valid/in_ready            fetch handshake; in_inst, in_pc payload
//   flush                        drop the held bundle, block capture
//   out_valid/out_ready          execute handshake
//   out_pc, rd, rs1, rs2, imm    decoded operands
//   alu_op, br_cond              ALU operation and branch condition
//   mem_wbmask, mem_size,
//   is_mem_sign                  memory access controls
//   inst_type, illegal           instruction class, undecodable flag
//   halted                       stage has retired an ECALL/EBREAK
module dec_stage
    import dec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_ID_W = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [XLEN-1:0]     in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [REG_ID_W-1:0] rd,
    output logic [REG_ID_W-1:0] rs1,
    output logic [REG_ID_W-1:0] rs2,
    output logic [XLEN-1:0]     imm,
    output logic [3:0]          alu_op,
    output logic [2:0]          br_cond,
    output logic [XLEN/8-1:0]   mem_wbmask,
    output logic [1:0]          mem_size,
    output logic                is_mem_sign,
    output logic [3:0]          inst_type,
    output logic                illegal,
    output logic                halted
);

    localparam int MASK_W = XLEN / 8;

    state_e              state_reg, state_next;
    logic                out_valid_reg, out_valid_next;
    dec_ctrl_t           ctrl_reg, ctrl_next;
    logic [XLEN-1:0]     pc_reg;
    logic [XLEN-1:0]     imm_reg, imm_next;
    logic [REG_ID_W-1:0] rd_reg, rs1_reg, rs2_reg;
    logic [MASK_W-1:0]   wbmask_reg, wbmask_next;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    imm_sel_e            imm_sel;
    logic                legal;
    logic                store_ok;
    logic                env_held;
    logic                out_fire;
    logic                capture;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_next             = '0;
        ctrl_next.br_cond     = funct3;
        ctrl_next.is_mem_sign = ~funct3[2];
        imm_sel               = IMM_NONE;
        legal                 = 1'b1;
        store_ok              = 1'b0;

        case (opcode)
            OPC_OP_IMM: begin
                ctrl_next.inst_type = INST_IMM;
                imm_sel             = IMM_I;
                // Only the shift-right form uses inst[30]; for the other
                // funct3 values that bit is immediate data, not an opcode bit.
                ctrl_next.alu_op    = {in_inst[30] & (funct3 == F3_SRX), funct3};
            end
            OPC_OP: begin
                ctrl_next.inst_type = INST_REG;
                ctrl_next.alu_op    = {in_inst[30], funct3};
            end
            OPC_LUI: begin
                ctrl_next.inst_type = INST_LUI;
                imm_sel             = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl_next.inst_type = INST_AUIPC;
                imm_sel             = IMM_U;
            end
            OPC_JAL: begin
                ctrl_next.inst_type = INST_JAL;
                imm_sel             = IMM_J;
            end
            OPC_JALR: begin
                ctrl_next.inst_type = INST_JALR;
                imm_sel             = IMM_I;
                legal               = (funct3 == F3_JALR);
            end
            OPC_BRANCH: begin
                ctrl_next.inst_type = INST_BRANCH;
                imm_sel             = IMM_B;
                legal               = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_LOAD: begin
                ctrl_next.inst_type = INST_LOAD;
                imm_sel             = IMM_I;
                // Every legal load width happens to equal funct3[1:0].
                ctrl_next.mem_size  = funct3[1:0];
                case (funct3)
                    F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
                    F3_LD, F3_LWU:                        legal = (XLEN == 64);
                    default:                              legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                ctrl_next.inst_type = INST_STORE;
                imm_sel             = IMM_S;
                ctrl_next.mem_size  = funct3[1:0];
                legal               = !funct3[2] && ((funct3[1:0] != 2'b11) || (XLEN == 64));
                store_ok            = legal;
            end
            OPC_FENCE: begin
                ctrl_next.inst_type = INST_FENCE;
            end
            OPC_SYSTEM: begin
                ctrl_next.inst_type = INST_ENV;
                legal               = (funct3 == F3_PRIV);
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        // Anything undecodable collapses to a clean illegal bundle so execute
        // never sees half-decoded controls.
        if (!legal) begin
            ctrl_next.inst_type = INST_ILLEGAL;
            ctrl_next.illegal   = 1'b1;
            ctrl_next.alu_op    = '0;
            ctrl_next.mem_size  = '0;
            imm_sel             = IMM_NONE;
            store_ok            = 1'b0;
        end
    end

    dec_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .inst (in_inst[31:7]),
        .sel  (imm_sel),
        .imm  (imm_next)
    );

    // Byte gi of the store mask is written when the access covers at least
    // gi+1 bytes, i.e. when log2(size) reaches the level that byte needs.
    generate
        for (genvar gi = 0; gi < MASK_W; gi++) begin : g_wbmask
            localparam int NEED = (gi == 0) ? 0 : (gi == 1) ? 1 : (gi < 4) ? 2 : 3;
            assign wbmask_next[gi] = store_ok && (funct3[1:0] >= NEED[1:0]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake and halt control
    // ------------------------------------------------------------------
    // While an ENV bundle is held nothing new is taken in: once it leaves the
    // stage halts, and a younger instruction must not be left stranded in
    // the output register of a halted stage.
    assign env_held = out_valid_reg && (ctrl_reg.inst_type == INST_ENV);
    assign in_ready = (state_reg == ST_RUN) && (!out_valid_reg || out_ready) && !flush && !env_held;
    assign capture  = in_valid && in_ready;
    // A flush in the same cycle cancels the downstream handshake.
    assign out_fire = out_valid_reg && out_ready && !flush;

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;

        if ((state_reg == ST_RUN) && out_fire && env_held) begin
            state_next = ST_HALT;
        end

        if (flush) begin
            out_valid_next = 1'b0;
        end else if (capture) begin
            out_valid_next = 1'b1;
        end else if (out_fire) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            out_valid_reg <= 1'b0;
            ctrl_reg      <= '0;
            pc_reg        <= '0;
            imm_reg       <= '0;
            rd_reg        <= '0;
            rs1_reg       <= '0;
            rs2_reg       <= '0;
            wbmask_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            if (capture) begin
                ctrl_reg   <= ctrl_next;
                pc_reg     <= in_pc;
                imm_reg    <= imm_next;
                rd_reg     <= REG_ID_W'(in_inst[11:7]);
                rs1_reg    <= REG_ID_W'(in_inst[19:15]);
                rs2_reg    <= REG_ID_W'(in_inst[24:20]);
                wbmask_reg <= wbmask_next;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_pc      = pc_reg;
    assign rd          = rd_reg;
    assign rs1         = rs1_reg;
    assign rs2         = rs2_reg;
    assign imm         = imm_reg;
    assign alu_op      = ctrl_reg.alu_op;
    assign br_cond     = ctrl_reg.br_cond;
    assign mem_wbmask  = wbmask_reg;
    assign mem_size    = ctrl_reg.mem_size;
    assign is_mem_sign = ctrl_reg.is_mem_sign;
    assign inst_type   = ctrl_reg.inst_type;
    assign illegal     = ctrl_reg.illegal;
    assign halted      = (state_reg == ST_HALT);

endmodule
